// File: rtl/inst_fetch_queue_if.sv
// Fetch-side SRAM-like request/response signals plus the decoder-facing valid/ready head.
interface inst_fetch_queue_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        out_adel;

  modport master (
    output inst_req, inst_addr, out_valid, out_ins, out_pc, out_adel,
    input  inst_addr_ok, inst_data_ok, inst_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  inst_req, inst_addr, out_valid, out_ins, out_pc, out_adel,
    output inst_addr_ok, inst_data_ok, inst_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues in-order fetches, buffers {ins, pc, adel} in a FIFO for the
// decoder, and drops in-flight responses after a redirect.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic                 clk,
  input logic                 rst,
  inst_fetch_queue_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   fifo_ins_q  [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic          fifo_adel_q [DEPTH];

  logic [CW-1:0] live;
  logic [CW:0]   occupancy;
  logic          aligned, req, addr_hs, resp_push, adel_push, push, pop;
  logic [31:0]   push_ins, push_pc;
  logic          push_adel;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    live      = outstanding_q - drop_cnt_q;
    occupancy = {1'b0, count_q} + {1'b0, live};
    aligned   = (fetch_pc_q[1:0] == 2'b00);
    req       = !rst && !bus.redirect && (state_q == StFetch) && aligned &&
                (occupancy < (CW + 1)'(DEPTH));
    addr_hs   = req && bus.inst_addr_ok;
    resp_push = bus.inst_data_ok && (drop_cnt_q == '0) && !bus.redirect;
    // Misaligned PC: wait until every live fetch has landed so the AdEL entry stays in order.
    adel_push = (state_q == StFetch) && !aligned && (live == '0) &&
                (count_q < CW'(DEPTH)) && !bus.redirect && !resp_push;
    push      = resp_push || adel_push;
    pop       = (count_q != '0) && bus.out_ready && !bus.redirect;
    push_ins  = resp_push ? bus.inst_rdata : '0;
    push_pc   = resp_push ? resp_pc_q : fetch_pc_q;
    push_adel = !resp_push;

    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (bus.redirect) begin
      state_d       = StFetch;
      fetch_pc_d    = bus.redirect_pc;
      resp_pc_d     = bus.redirect_pc;
      outstanding_d = outstanding_q - CW'(bus.inst_data_ok);
      drop_cnt_d    = outstanding_q - CW'(bus.inst_data_ok);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      outstanding_d = outstanding_q + CW'(addr_hs) - CW'(bus.inst_data_ok);
      count_d       = count_q + CW'(push) - CW'(pop);
      if (bus.inst_data_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if (addr_hs)   fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_push) resp_pc_d  = resp_pc_q + 32'd4;
      if (adel_push) state_d    = StHold;
      if (push)      wr_ptr_d   = ptr_inc(wr_ptr_q);
      if (pop)       rd_ptr_d   = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage needs no reset: visibility is governed by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ins_q[wr_ptr_q]  <= push_ins;
      fifo_pc_q[wr_ptr_q]   <= push_pc;
      fifo_adel_q[wr_ptr_q] <= push_adel;
    end
  end

  always_comb begin
    bus.inst_req  = req;
    bus.inst_addr = fetch_pc_q;
    bus.out_valid = (count_q != '0);
    bus.out_ins   = bus.out_valid ? fifo_ins_q[rd_ptr_q] : '0;
    bus.out_pc    = bus.out_valid ? fifo_pc_q[rd_ptr_q] : '0;
    bus.out_adel  = bus.out_valid ? fifo_adel_q[rd_ptr_q] : 1'b0;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, corner-case sequences, then random
// traffic checked against a queue-based reference model.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hBFC0_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  typedef struct {
    bit          aok;
    bit          dok;
    logic [31:0] rd;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] ins;
    logic [31:0] pc;
  } vec_t;

  // Reference model state
  entry_t      mq[$];
  logic [31:0] pend[$];
  logic [31:0] m_fetch, m_resp;
  int          m_out, m_drop;
  bit          m_hold;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit aok, input bit dok, input logic [31:0] rd, input bit rdy,
                       input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = rd;
    bus.out_ready    = rdy;
    bus.redirect     = redir;
    bus.redirect_pc  = rpc;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.out_ready    = 1'b0;
    bus.redirect     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  function automatic void model_reset();
    mq.delete();
    pend.delete();
    m_fetch = 32'hBFC0_0000;
    m_resp  = 32'hBFC0_0000;
    m_out   = 0;
    m_drop  = 0;
    m_hold  = 1'b0;
  endfunction

  function automatic bit model_req(input bit r, input bit redir);
    return !r && !m_hold && !redir && (m_fetch[1:0] == 2'b00) &&
           (mq.size() + m_out - m_drop < 4);
  endfunction

  vec_t tv[7];

  initial begin
    bit          hs_prev;
    int          hs_cnt;
    bit          r_rst, redir, aok, dok, rdy, ereq;
    logic [31:0] rpc, rd, tmp;
    int          live, old_size;
    bit          pushed;
    entry_t      e;

    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    bus.out_ready    = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;

    // Reset state, sampled while rst is still high
    repeat (2) @(negedge clk);
    #1;
    chk1("reset_req", bus.inst_req, 1'b0);
    chk1("reset_valid", bus.out_valid, 1'b0);
    chk32("reset_ins", bus.out_ins, 32'h0);
    chk32("reset_pc", bus.out_pc, 32'h0);
    chk1("reset_adel", bus.out_adel, 1'b0);
    chk32("reset_addr", bus.inst_addr, 32'hBFC0_0000);
    rst = 1'b0;

    // Directed table: in-order fetch, response and pop, rdata = pc ^ 1234
    tv[0] = '{1, 0, 32'h0,         0, 1, 32'hBFC0_0000, 0, 32'h0,         32'h0};
    tv[1] = '{1, 1, 32'hBFC0_1234, 0, 1, 32'hBFC0_0004, 0, 32'h0,         32'h0};
    tv[2] = '{1, 1, 32'hBFC0_1230, 1, 1, 32'hBFC0_0008, 1, 32'hBFC0_1234, 32'hBFC0_0000};
    tv[3] = '{0, 1, 32'hBFC0_123C, 0, 1, 32'hBFC0_000C, 1, 32'hBFC0_1230, 32'hBFC0_0004};
    tv[4] = '{0, 0, 32'h0,         1, 1, 32'hBFC0_000C, 1, 32'hBFC0_1230, 32'hBFC0_0004};
    tv[5] = '{0, 0, 32'h0,         1, 1, 32'hBFC0_000C, 1, 32'hBFC0_123C, 32'hBFC0_0008};
    tv[6] = '{0, 0, 32'h0,         0, 1, 32'hBFC0_000C, 0, 32'h0,         32'h0};
    for (int i = 0; i < 7; i++) begin
      drive(tv[i].aok, tv[i].dok, tv[i].rd, tv[i].rdy, 1'b0, 32'h0);
      chk1($sformatf("tv%0d_req", i), bus.inst_req, tv[i].req);
      chk32($sformatf("tv%0d_addr", i), bus.inst_addr, tv[i].addr);
      chk1($sformatf("tv%0d_valid", i), bus.out_valid, tv[i].vld);
      chk32($sformatf("tv%0d_ins", i), bus.out_ins, tv[i].ins);
      chk32($sformatf("tv%0d_pc", i), bus.out_pc, tv[i].pc);
      chk1($sformatf("tv%0d_adel", i), bus.out_adel, 1'b0);
    end

    // Capacity: stalled decoder admits exactly DEPTH fetches, one pop frees one more
    pulse_rst();
    hs_prev = 1'b0;
    hs_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, hs_prev, 32'h1, 1'b0, 1'b0, 32'h0);
      hs_prev = bus.inst_req;
      if (bus.inst_req) hs_cnt++;
    end
    chk32("cap_full_reqs", 32'(hs_cnt), 32'd4);
    chk1("cap_full_req_low", bus.inst_req, 1'b0);
    drive(1'b1, hs_prev, 32'h1, 1'b1, 1'b0, 32'h0);
    hs_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, hs_prev, 32'h1, 1'b0, 1'b0, 32'h0);
      hs_prev = bus.inst_req;
      if (bus.inst_req) hs_cnt++;
    end
    chk32("cap_after_pop_reqs", 32'(hs_cnt), 32'd5);

    // Redirect with two fetches in flight: both late responses dropped
    pulse_rst();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0100);
    chk1("redir_req_low", bus.inst_req, 1'b0);
    drive(1'b0, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0);
    chk1("redir_empty", bus.out_valid, 1'b0);
    chk32("redir_addr", bus.inst_addr, 32'h8000_0100);
    drive(1'b0, 1'b1, 32'hDEAD_0004, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("redir_drop_empty", bus.out_valid, 1'b0);
    drive(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0);
    idle();
    chk1("redir_first_valid", bus.out_valid, 1'b1);
    chk32("redir_first_pc", bus.out_pc, 32'h8000_0100);
    chk32("redir_first_ins", bus.out_ins, 32'hCAFE_0001);

    // Misaligned redirect: single AdEL entry, fetch held until next redirect
    pulse_rst();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0102);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("adel_req0", bus.inst_req, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk1("adel_valid", bus.out_valid, 1'b1);
    chk32("adel_pc", bus.out_pc, 32'h8000_0102);
    chk32("adel_ins", bus.out_ins, 32'h0);
    chk1("adel_flag", bus.out_adel, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk1("adel_hold_req", bus.inst_req, 1'b0);
      chk1("adel_single", bus.out_valid, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0200);
    idle();
    chk1("adel_exit_req", bus.inst_req, 1'b1);
    chk32("adel_exit_addr", bus.inst_addr, 32'h8000_0200);

    // Redirect + data_ok + pop in one cycle with two outstanding
    pulse_rst();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h2222_0000, 1'b1, 1'b1, 32'h8000_0300);
    chk1("rdp_req_low", bus.inst_req, 1'b0);
    chk1("rdp_valid_before", bus.out_valid, 1'b1);
    drive(1'b0, 1'b1, 32'h3333_0000, 1'b0, 1'b0, 32'h0);
    chk1("rdp_empty", bus.out_valid, 1'b0);
    chk1("rdp_req", bus.inst_req, 1'b1);
    idle();
    chk1("rdp_dropped", bus.out_valid, 1'b0);

    // Reset mid-operation with 3 queued and 1 outstanding
    pulse_rst();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h2, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h3, 1'b0, 1'b0, 32'h0);
    idle();
    chk1("mrst_full_valid", bus.out_valid, 1'b1);
    chk1("mrst_full_req", bus.inst_req, 1'b0);
    pulse_rst();
    chk1("mrst_valid", bus.out_valid, 1'b0);
    chk32("mrst_addr", bus.inst_addr, 32'hBFC0_0000);
    chk1("mrst_req", bus.inst_req, 1'b1);

    // Random traffic against the reference model
    pulse_rst();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rst = ($urandom_range(399) == 0);
      redir = !r_rst && ($urandom_range(29) == 0);
      tmp   = $urandom;
      case ($urandom_range(4))
        0:       rpc = 32'h8000_0100;
        1:       rpc = 32'h8000_0102;
        2:       rpc = 32'hFFFF_FFF8;
        3:       begin rpc = tmp; rpc[1:0] = 2'b00; end
        default: rpc = tmp;
      endcase
      aok = ($urandom_range(3) != 0);
      dok = (pend.size() > 0) && ($urandom_range(2) != 0);
      rd  = dok ? (pend[0] ^ 32'h0000_1234) : $urandom;
      rdy = $urandom_range(1) == 1;

      @(negedge clk);
      rst              = r_rst;
      bus.inst_addr_ok = aok;
      bus.inst_data_ok = dok;
      bus.inst_rdata   = rd;
      bus.out_ready    = rdy;
      bus.redirect     = redir;
      bus.redirect_pc  = rpc;
      #1;

      ereq = model_req(r_rst, redir);
      chk1("rnd_req", bus.inst_req, ereq);
      chk32("rnd_addr", bus.inst_addr, m_fetch);
      chk1("rnd_valid", bus.out_valid, mq.size() > 0);
      chk32("rnd_ins", bus.out_ins, (mq.size() > 0) ? mq[0].ins : 32'h0);
      chk32("rnd_pc", bus.out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
      chk1("rnd_adel", bus.out_adel, (mq.size() > 0) ? mq[0].adel : 1'b0);

      if (r_rst) begin
        model_reset();
      end else begin
        live     = m_out - m_drop;
        old_size = mq.size();
        if (dok) void'(pend.pop_front());
        if (redir) begin
          mq.delete();
          m_fetch = rpc;
          m_resp  = rpc;
          m_hold  = 1'b0;
          m_out   = m_out - int'(dok);
          m_drop  = m_out;
        end else begin
          pushed = 1'b0;
          if (rdy && mq.size() > 0) void'(mq.pop_front());
          if (dok) begin
            m_out--;
            if (m_drop > 0) begin
              m_drop--;
            end else begin
              e = '{rd, m_resp, 1'b0};
              mq.push_back(e);
              m_resp += 32'd4;
              pushed = 1'b1;
            end
          end
          if (!pushed && !m_hold && m_fetch[1:0] != 2'b00 && live == 0 && old_size < 4) begin
            e = '{32'h0, m_fetch, 1'b1};
            mq.push_back(e);
            m_hold = 1'b1;
          end
          if (ereq && aok) begin
            pend.push_back(m_fetch);
            m_fetch += 32'd4;
            m_out++;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
